// File: rtl/gray_pkg.sv
// Shared types and conversion helpers for the registered Gray-code counter.
// Helpers operate at MAX_W bits; callers zero-extend and truncate to their width.
package gray_pkg;

   localparam int MAX_W = 32;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_e;

   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Top bit passes through; each lower bit folds in the binary bit above it.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = MAX_W-2; i >= 0; i--) begin
         b[i] = g[i] ^ b[i+1];
      end
      return b;
   endfunction

endpackage

// File: rtl/conv_gray_bin.sv
// Combinational Gray-to-binary converter used on the counter's load path.
module conv_gray_bin
   import gray_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   // Zero upper bits leave the lower WIDTH bits of the wide conversion correct.
   assign bin_o = WIDTH'(gray2bin(MAX_W'(gray_i)));

endmodule

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with binary/Gray load, clear, wrap or saturate,
// and a one-cycle boundary pulse. The Gray output comes straight from a flop, so it is CDC-safe.
module gray_counter
   import gray_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter bit WRAP    = 1'b1,
   parameter int RST_VAL = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             dir_i,
   input  logic             load_i,
   input  logic             ld_gray_i,
   input  logic [WIDTH-1:0] ld_val_i,
   output logic [WIDTH-1:0] bin_o,
   output logic [WIDTH-1:0] gray_o,
   output logic             bnd_o
);

   if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
      $error("gray_counter: WIDTH must be between 2 and %0d", MAX_W);
   end
   if (RST_VAL < 0 || longint'(RST_VAL) >= (longint'(1) << WIDTH)) begin : g_bad_rst
      $error("gray_counter: RST_VAL must be below 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] RST_B = WIDTH'(RST_VAL);
   localparam logic [WIDTH-1:0] RST_G = RST_B ^ (RST_B >> 1);
   localparam logic [WIDTH-1:0] MAX_B = '1;

   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] gray_q;
   logic             bnd_q;
   logic [WIDTH-1:0] ld_bin;
   logic [WIDTH-1:0] next_bin;
   logic [WIDTH-1:0] next_gray;
   logic             next_bnd;
   dir_e             dir;

   assign dir = dir_e'(dir_i);

   conv_gray_bin #(.WIDTH(WIDTH)) u_conv (
      .gray_i (ld_val_i),
      .bin_o  (ld_bin)
   );

   // Next-state selection: clear beats load beats count. A count that would cross
   // the range edge raises the boundary pulse, then either wraps or holds.
   always_comb begin
      next_bin = bin_q;
      next_bnd = 1'b0;
      if (clr_i) begin
         next_bin = RST_B;
      end else if (load_i) begin
         next_bin = ld_gray_i ? ld_bin : ld_val_i;
      end else if (en_i) begin
         if (dir == DIR_UP) begin
            if (bin_q == MAX_B) begin
               next_bnd = 1'b1;
               next_bin = WRAP ? '0 : bin_q;
            end else begin
               next_bin = bin_q + 1'b1;
            end
         end else begin
            if (bin_q == '0) begin
               next_bnd = 1'b1;
               next_bin = WRAP ? MAX_B : bin_q;
            end else begin
               next_bin = bin_q - 1'b1;
            end
         end
      end
   end

   assign next_gray = WIDTH'(bin2gray(MAX_W'(next_bin)));

   // Binary and Gray copies update on the same edge, so gray_o always matches bin_o.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bin_q  <= RST_B;
         gray_q <= RST_G;
         bnd_q  <= 1'b0;
      end else begin
         bin_q  <= next_bin;
         gray_q <= next_gray;
         bnd_q  <= next_bnd;
      end
   end

   assign bin_o  = bin_q;
   assign gray_o = gray_q;
   assign bnd_o  = bnd_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: a wrapping and a saturating instance share one stimulus stream
// and are checked against an arithmetic model every cycle plus hand-computed literals.
module tb_gray_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clr = 1'b0;
   logic       en = 1'b0;
   logic       dir = 1'b0;
   logic       load = 1'b0;
   logic       ldGray = 1'b0;
   logic [3:0] ldVal = 4'd0;

   logic [3:0] binW, grayW, binS, grayS;
   logic       bndW, bndS;

   int total = 0;
   int bad = 0;

   // Model state: index 0 is the wrapping instance, index 1 the saturating one.
   int mBin[2];
   bit mBnd[2];
   bit mStepped;
   logic [3:0] prevGrayW;

   gray_counter #(.WIDTH(4), .WRAP(1'b1), .RST_VAL(5)) dutWrap (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en), .dir_i(dir),
      .load_i(load), .ld_gray_i(ldGray), .ld_val_i(ldVal),
      .bin_o(binW), .gray_o(grayW), .bnd_o(bndW)
   );

   gray_counter #(.WIDTH(4), .WRAP(1'b0), .RST_VAL(5)) dutSat (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en), .dir_i(dir),
      .load_i(load), .ld_gray_i(ldGray), .ld_val_i(ldVal),
      .bin_o(binS), .gray_o(grayS), .bnd_o(bndS)
   );

   always #5 clk = ~clk;

   function automatic int grayOf(input int b);
      return b ^ (b >> 1);
   endfunction

   // Inverse Gray by search: the unique 4-bit value whose Gray code matches.
   function automatic int binOfGray(input int g);
      int r = 0;
      for (int b = 0; b < 16; b++) if (grayOf(b) == g) r = b;
      return r;
   endfunction

   function automatic int stepTarget(input int cur);
      return dir ? cur - 1 : cur + 1;
   endfunction

   function automatic int modelNextBin(input int cur, input bit wrapMode);
      int n;
      if (clr) return 5;
      if (load) return ldGray ? binOfGray(int'(ldVal)) : int'(ldVal);
      if (!en) return cur;
      n = stepTarget(cur);
      if (n < 0 || n > 15) return wrapMode ? (n + 16) % 16 : cur;
      return n;
   endfunction

   function automatic bit modelNextBnd(input int cur);
      int n;
      if (clr || load || !en) return 1'b0;
      n = stepTarget(cur);
      return (n < 0 || n > 15);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mBin[0]  <= 5;
         mBin[1]  <= 5;
         mBnd[0]  <= 1'b0;
         mBnd[1]  <= 1'b0;
         mStepped <= 1'b0;
      end else begin
         mBin[0]  <= modelNextBin(mBin[0], 1'b1);
         mBin[1]  <= modelNextBin(mBin[1], 1'b0);
         mBnd[0]  <= modelNextBnd(mBin[0]);
         mBnd[1]  <= modelNextBnd(mBin[1]);
         mStepped <= en && !clr && !load;
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, plus the one-bit Gray step rule.
   always @(negedge clk) begin
      checkOutput("wrap.bin", int'(binW), mBin[0]);
      checkOutput("wrap.gray", int'(grayW), grayOf(mBin[0]));
      checkOutput("wrap.bnd", int'(bndW), int'(mBnd[0]));
      checkOutput("sat.bin", int'(binS), mBin[1]);
      checkOutput("sat.gray", int'(grayS), grayOf(mBin[1]));
      checkOutput("sat.bnd", int'(bndS), int'(mBnd[1]));
      if (mStepped) checkOutput("wrap.gray_one_bit", $countones(grayW ^ prevGrayW), 1);
      prevGrayW = grayW;
   end

   task automatic applyStimulus(input bit c, input bit l, input bit g, input logic [3:0] v,
                                input bit e, input bit d);
      clr = c; load = l; ldGray = g; ldVal = v; en = e; dir = d;
      @(negedge clk);
   endtask

   initial begin
      int satBin[4] = '{1, 0, 0, 0};
      int satBnd[4] = '{0, 0, 1, 1};

      #1 rst = 1'b1;
      #1;
      $display("[TB] async reset check before any clock edge");
      checkOutput("reset.bin", int'(binW), 5);
      checkOutput("reset.gray", int'(grayW), 7);
      checkOutput("reset.bnd", int'(bndW), 0);
      checkOutput("reset.sat_bin", int'(binS), 5);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] count up from 0 for 17 cycles");
      applyStimulus(0, 1, 0, 4'd0, 0, 0);
      checkOutput("load0.bin", int'(binW), 0);
      for (int i = 0; i < 17; i++) begin
         applyStimulus(0, 0, 0, 4'd0, 1, 0);
         if (i == 14) begin
            checkOutput("up15.bin", int'(binW), 15);
            checkOutput("up15.gray", int'(grayW), 8);
            checkOutput("up15.bnd", int'(bndW), 0);
         end
         if (i == 15) begin
            checkOutput("wrap0.bin", int'(binW), 0);
            checkOutput("wrap0.gray", int'(grayW), 0);
            checkOutput("wrap0.bnd", int'(bndW), 1);
         end
      end
      checkOutput("up17.bin", int'(binW), 1);
      checkOutput("up17.bnd", int'(bndW), 0);
      checkOutput("sat_hi.bin", int'(binS), 15);
      checkOutput("sat_hi.bnd", int'(bndS), 1);

      $display("[TB] count down from 2 for 4 cycles");
      applyStimulus(0, 1, 0, 4'd2, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 4'd0, 1, 1);
         checkOutput("sat_dn.bin", int'(binS), satBin[i]);
         checkOutput("sat_dn.bnd", int'(bndS), satBnd[i]);
      end
      checkOutput("wrap_dn.bin", int'(binW), 14);

      $display("[TB] Gray and binary loads");
      applyStimulus(0, 1, 1, 4'b1101, 0, 0);
      checkOutput("ldgray.bin", int'(binW), 9);
      checkOutput("ldgray.gray", int'(grayW), 13);
      checkOutput("ldgray.bnd", int'(bndW), 0);
      applyStimulus(0, 1, 0, 4'd6, 0, 0);
      checkOutput("ldbin.bin", int'(binW), 6);
      checkOutput("ldbin.gray", int'(grayW), 5);

      $display("[TB] priority clr > load > en");
      applyStimulus(0, 1, 0, 4'd10, 0, 0);
      applyStimulus(1, 1, 0, 4'd7, 1, 0);
      checkOutput("clr_wins.bin", int'(binW), 5);
      applyStimulus(0, 1, 0, 4'd3, 1, 0);
      checkOutput("load_wins.bin", int'(binW), 3);

      $display("[TB] reset mid-count");
      applyStimulus(0, 1, 0, 4'd10, 0, 0);
      applyStimulus(0, 0, 0, 4'd0, 1, 0);
      applyStimulus(0, 0, 0, 4'd0, 1, 0);
      checkOutput("pre_rst.bin", int'(binW), 12);
      #2 rst = 1'b1;
      #1;
      checkOutput("mid_rst.bin", int'(binW), 5);
      checkOutput("mid_rst.gray", int'(grayW), 7);
      checkOutput("mid_rst.bnd", int'(bndW), 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 0, 0, 4'd0, 1, 0);
      checkOutput("resume.bin", int'(binW), 6);
      applyStimulus(0, 0, 0, 4'd0, 0, 1);
      checkOutput("hold.bin", int'(binW), 6);
      checkOutput("hold.bnd", int'(bndW), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised, registered Gray-code counter. Sequential successor of the combinational binary-to-Gray converter.
- Keeps a binary count and a Gray-coded copy, both as flops. The Gray output comes straight from a register, so it is glitch-free and can be sampled safely in another clock domain.
- Used as the read/write pointer source for async FIFOs and for CDC-safe event counters.
- Adds up/down counting, load (binary or Gray), synchronous clear, wrap or saturate mode, and a boundary event flag.

Parameters:
- WIDTH, 4, counter width in bits; must be >= 2 (elaboration assertion).
- WRAP, 1, 1: wrap modulo 2^WIDTH; 0: saturate at 0 and 2^WIDTH-1.
- RST_VAL, 0, binary reset value; must be < 2^WIDTH.

Ports:
- clk_i  in  1  clock; all flops rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- clr_i  in  1  synchronous clear to RST_VAL.
- en_i  in  1  count enable; one step per cycle.
- dir_i  in  1  0: count up, 1: count down.
- load_i  in  1  synchronous load of ld_val_i.
- ld_gray_i  in  1  1: ld_val_i is Gray-coded; 0: ld_val_i is binary.
- ld_val_i  in  WIDTH  load value.
- bin_o  out  WIDTH  registered binary count.
- gray_o  out  WIDTH  registered Gray count; always equals bin2gray(bin_o).
- bnd_o  out  1  registered one-cycle pulse on a boundary event.

Behaviour:
- Reset (rst_i high, asynchronous):
  - bin_o = RST_VAL, gray_o = RST_VAL ^ (RST_VAL >> 1), bnd_o = 0.
  - Reset deasserting mid-operation: the counter restarts from RST_VAL; no partial update survives.
- Per-cycle priority: clr_i > load_i > en_i > hold.
  - clr: bin_o = RST_VAL next cycle; bnd_o = 0.
  - load with ld_gray_i = 0: bin_o = ld_val_i.
  - load with ld_gray_i = 1: bin_o = gray2bin(ld_val_i), where bit WIDTH-1 passes through and bit i = g[i] ^ b[i+1].
  - Load never asserts bnd_o.
  - en_i with dir_i = 0: next = bin_o + 1.
  - en_i with dir_i = 1: next = bin_o - 1.
  - Arithmetic is WIDTH bits, unsigned.
- Boundary (en_i and no clr/load):
  - Up from 2^WIDTH-1, or down from 0.
  - WRAP = 1: the value wraps (15 -> 0, 0 -> 15) and bnd_o pulses high for the following cycle.
  - WRAP = 0: the value holds at the boundary and bnd_o pulses high for the following cycle. Each blocked attempt produces its own pulse, so bnd_o stays high while en_i persists at the boundary.
- Latency: one cycle from input sample to bin_o/gray_o/bnd_o update.
- No combinational path from any input to any output.
- gray_q is computed from next-state binary and registered in the same edge as bin_q. Consequences:
  - gray_o changes in exactly one bit per enabled step in wrap mode, including at the wrap.
  - On load/clear, gray_o may change in several bits.
- dir_i may change every cycle. It is sampled only when en_i = 1 and neither clr_i nor load_i is asserted.
- en_i = 0 with no clr/load: all outputs hold; bnd_o = 0.

Decomposition:
- gray_pkg holds:
  - functions bin2gray and gray2bin (WIDTH-generic via a parametrised class static or a max-width function).
  - localparam typedef dir_e {DIR_UP = 1'b0, DIR_DN = 1'b1}.
- Sub-module conv_gray_bin (WIDTH parameter, gray_i -> bin_o, combinational) performs the load-path conversion.
- The existing binary-to-Gray converter is instantiated on the next-state value.

Test Plan:
- Reset with RST_VAL=5, WIDTH=4: bin_o=5, gray_o=7, bnd_o=0 asynchronously, without a clock edge.
- Count up WRAP=1 from 0, en_i=1 for 17 cycles:
  - bin_o goes 0..15,0,1; gray_o goes 0,1,3,2,6,...,8,0,1.
  - Checker confirms exactly one gray bit toggles per step.
  - bnd_o is high only in the cycle after 15 -> 0.
- Count down WRAP=0 from 2, en_i=1 for 4 cycles: bin_o = 1, 0, 0, 0; bnd_o = 0, 0, 1, 1.
- Load Gray 4'b1101 (ld_gray_i=1): bin_o = 9, gray_o = 13, bnd_o = 0. Load binary 6: bin_o = 6, gray_o = 5.
- Simultaneous clr_i=1, load_i=1, en_i=1 at bin_o=10: bin_o = RST_VAL next cycle. Then load_i=1, en_i=1 with ld_val_i=3: bin_o = 3 (load wins over count).
- Assert rst_i mid-count at bin_o=12 between clock edges: outputs go to reset values immediately. After release, counting resumes from RST_VAL on the first enabled edge.
